// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared constants for the instruction-memory program loader:
//   instruction word width, instruction memory depth/address width,
//   and the loader state encoding.
package imem_loader_pkg;

    localparam int IMEM_ISIZE = 32;
    localparam int IMEM_DEPTH = 256;
    localparam int IMEM_AW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } load_state_t;

endpackage

// File: rtl/imem_loader.sv
// imem_loader
//   Program-load front end for the instruction memory. Accepts instruction
//   words over a valid/ready handshake and writes them to consecutive word
//   addresses through the memory write port, holding the core in reset
//   until the last word has been committed.
//
//   State table
//   state   | meaning
//   IDLE    | after reset, waiting for load_start, core held in reset
//   LOAD    | accepting words, one write per handshake
//   DONE    | last word written; core released one cycle after entry
//   ERR     | program overran DEPTH; waits for load_start or rst
//
//   Ports
//   clk, rst          clock, async active-high reset
//   load_start        begin (re)load; ignored while loading
//   in_valid/in_data/in_last/in_ready   word stream handshake
//   mem_wen/mem_addr/mem_data           instruction-memory write port
//   cpu_rst           hold-reset for the core
//   done, error       load outcome
//   word_count        words written in the current/last load
//   checksum          modulo-2^ISIZE sum of the words written
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ISIZE = IMEM_ISIZE,
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             in_valid,
    input  logic [ISIZE-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             mem_wen,
    output logic [ISIZE-1:0] mem_addr,
    output logic [ISIZE-1:0] mem_data,
    output logic             cpu_rst,
    output logic             done,
    output logic             error,
    output logic [AW:0]      word_count,
    output logic [ISIZE-1:0] checksum
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    load_state_t state, state_nxt;
    logic [AW-1:0] addr_cnt;
    logic          hs;
    logic          start_ok;

    assign in_ready = (state == ST_LOAD);
    assign hs       = in_valid && in_ready;
    assign start_ok = load_start && (state != ST_LOAD);
    assign done     = (state == ST_DONE);
    assign error    = (state == ST_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (load_start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (hs && in_last) begin
                    state_nxt = ST_DONE;
                end else if (hs && (addr_cnt == LAST_ADDR)) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_DONE: if (load_start) state_nxt = ST_LOAD;
            ST_ERR:  if (load_start) state_nxt = ST_LOAD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write port and running totals. The counter wraps to zero on the
    // overflow word, which is harmless because ERR accepts nothing more.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_cnt   <= '0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            mem_wen <= hs;
            if (start_ok) begin
                addr_cnt   <= '0;
                word_count <= '0;
                checksum   <= '0;
            end else if (hs) begin
                mem_addr   <= {{(ISIZE-AW){1'b0}}, addr_cnt};
                mem_data   <= in_data;
                addr_cnt   <= addr_cnt + {{(AW-1){1'b0}}, 1'b1};
                word_count <= word_count + {{AW{1'b0}}, 1'b1};
                checksum   <= checksum + in_data;
            end
        end
    end

    // Registered so the core leaves reset one cycle after DONE is entered,
    // i.e. after the final write is in the array. A reload from DONE
    // reasserts it on the same edge that leaves DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rst <= 1'b1;
        end else begin
            cpu_rst <= !((state == ST_DONE) && !load_start);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [8:0]  word_count;
    logic [31:0] checksum;

    int checks = 0;
    int errors = 0;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error),
        .word_count (word_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ls;
        logic        v;
        logic [31:0] d;
        logic        last;
        logic        rdy;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic        cpu;
        logic        dn;
        logic        er;
        logic [8:0]  wc;
        logic [31:0] cs;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ls, input logic v, input logic [31:0] d, input logic last);
        load_start = ls;
        in_valid   = v;
        in_data    = d;
        in_last    = last;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, " in_ready"}, 64'(in_ready), 64'(e.rdy));
        chk({tag, " mem_wen"}, 64'(mem_wen), 64'(e.wen));
        if (e.wen) begin
            chk({tag, " mem_addr"}, 64'(mem_addr), 64'(e.addr));
            chk({tag, " mem_data"}, 64'(mem_data), 64'(e.data));
        end
        chk({tag, " cpu_rst"}, 64'(cpu_rst), 64'(e.cpu));
        chk({tag, " done"}, 64'(done), 64'(e.dn));
        chk({tag, " error"}, 64'(error), 64'(e.er));
        chk({tag, " word_count"}, 64'(word_count), 64'(e.wc));
        chk({tag, " checksum"}, 64'(checksum), 64'(e.cs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          ls  v   d             last rdy wen addr  data          cpu dn er wc  cs
        vecs[0]  = '{1, 0, 32'h0,         0,   1,  0,  0,    0,            1,  0, 0, 0, 32'h0};
        vecs[1]  = '{0, 1, 32'h1,         0,   1,  1,  0,    32'h1,        1,  0, 0, 1, 32'h1};
        vecs[2]  = '{1, 1, 32'h2,         0,   1,  1,  1,    32'h2,        1,  0, 0, 2, 32'h3};
        vecs[3]  = '{0, 1, 32'h3,         0,   1,  1,  2,    32'h3,        1,  0, 0, 3, 32'h6};
        vecs[4]  = '{0, 1, 32'h4,         1,   0,  1,  3,    32'h4,        1,  1, 0, 4, 32'hA};
        vecs[5]  = '{0, 0, 32'h0,         0,   0,  0,  0,    0,            0,  1, 0, 4, 32'hA};
        vecs[6]  = '{0, 1, 32'h55,        0,   0,  0,  0,    0,            0,  1, 0, 4, 32'hA};
        vecs[7]  = '{1, 0, 32'h0,         0,   1,  0,  0,    0,            1,  0, 0, 0, 32'h0};
        vecs[8]  = '{0, 1, 32'hDEADBEEF,  0,   1,  1,  0,    32'hDEADBEEF, 1,  0, 0, 1, 32'hDEADBEEF};
        vecs[9]  = '{0, 1, 32'h1,         1,   0,  1,  1,    32'h1,        1,  1, 0, 2, 32'hDEADBEF0};
        vecs[10] = '{0, 0, 32'h0,         0,   0,  0,  0,    0,            0,  1, 0, 2, 32'hDEADBEF0};

        // Reset, then idle with a word offered: nothing accepted.
        rst = 1'b1;
        drive(0, 1, 32'h12345678, 0);
        #3;
        chk("rst in_ready", 64'(in_ready), 64'(0));
        chk("rst mem_wen", 64'(mem_wen), 64'(0));
        chk("rst mem_addr", 64'(mem_addr), 64'(0));
        chk("rst mem_data", 64'(mem_data), 64'(0));
        chk("rst cpu_rst", 64'(cpu_rst), 64'(1));
        chk("rst done", 64'(done), 64'(0));
        chk("rst error", 64'(error), 64'(0));
        chk("rst word_count", 64'(word_count), 64'(0));
        chk("rst checksum", 64'(checksum), 64'(0));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle in_ready", 64'(in_ready), 64'(0));
            chk("idle mem_wen", 64'(mem_wen), 64'(0));
            chk("idle cpu_rst", 64'(cpu_rst), 64'(1));
        end

        // Back-to-back 4-word load, then a reload of two words from DONE.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].ls, vecs[i].v, vecs[i].d, vecs[i].last);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Same 4 words with 2-cycle gaps between them.
        drive(1, 0, 0, 0);
        tick();
        chk("gap reload done", 64'(done), 64'(0));
        chk("gap reload cpu_rst", 64'(cpu_rst), 64'(1));
        for (int w = 0; w < 4; w++) begin
            drive(0, 1, 32'(w + 1), (w == 3));
            tick();
            chk($sformatf("gap%0d wen", w), 64'(mem_wen), 64'(1));
            chk($sformatf("gap%0d addr", w), 64'(mem_addr), 64'(w));
            chk($sformatf("gap%0d data", w), 64'(mem_data), 64'(w + 1));
            drive(0, 0, 0, 0);
            if (w < 3) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    chk($sformatf("gap%0d idle wen", w), 64'(mem_wen), 64'(0));
                end
            end
        end
        chk("gap done", 64'(done), 64'(1));
        chk("gap cpu_rst at done", 64'(cpu_rst), 64'(1));
        chk("gap word_count", 64'(word_count), 64'(4));
        chk("gap checksum", 64'(checksum), 64'(32'hA));
        tick();
        chk("gap cpu_rst after", 64'(cpu_rst), 64'(0));

        // Overflow: 256 words 1..256 with no last.
        drive(1, 0, 0, 0);
        tick();
        for (int w = 0; w < 256; w++) begin
            drive(0, 1, 32'(w + 1), 0);
            tick();
            chk("ovf wen", 64'(mem_wen), 64'(1));
            chk("ovf addr", 64'(mem_addr), 64'(w));
            if (w < 255) chk("ovf error early", 64'(error), 64'(0));
        end
        chk("ovf error", 64'(error), 64'(1));
        chk("ovf cpu_rst", 64'(cpu_rst), 64'(1));
        chk("ovf in_ready", 64'(in_ready), 64'(0));
        chk("ovf word_count", 64'(word_count), 64'(256));
        chk("ovf checksum", 64'(checksum), 64'(32'h8080));
        tick();
        chk("ovf hold wen", 64'(mem_wen), 64'(0));
        chk("ovf hold error", 64'(error), 64'(1));
        chk("ovf hold in_ready", 64'(in_ready), 64'(0));
        chk("ovf hold cpu_rst", 64'(cpu_rst), 64'(1));

        // load_start from ERR restarts; rst after 2nd of 4 words.
        drive(1, 0, 0, 0);
        tick();
        chk("err restart in_ready", 64'(in_ready), 64'(1));
        chk("err restart error", 64'(error), 64'(0));
        chk("err restart word_count", 64'(word_count), 64'(0));
        drive(0, 1, 32'h11, 0);
        tick();
        drive(0, 1, 32'h22, 0);
        tick();
        chk("pre-rst wen", 64'(mem_wen), 64'(1));
        chk("pre-rst addr", 64'(mem_addr), 64'(1));
        drive(0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst wen", 64'(mem_wen), 64'(0));
        chk("midrst in_ready", 64'(in_ready), 64'(0));
        chk("midrst cpu_rst", 64'(cpu_rst), 64'(1));
        chk("midrst word_count", 64'(word_count), 64'(0));
        chk("midrst checksum", 64'(checksum), 64'(0));
        rst = 1'b0;
        tick();
        chk("post-rst idle in_ready", 64'(in_ready), 64'(0));
        drive(1, 0, 0, 0);
        tick();
        drive(0, 1, 32'h33, 0);
        tick();
        chk("restart wen", 64'(mem_wen), 64'(1));
        chk("restart addr", 64'(mem_addr), 64'(0));
        chk("restart data", 64'(mem_data), 64'(32'h33));
        chk("restart word_count", 64'(word_count), 64'(1));
        drive(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program-load front end for the instruction memory: it accepts a stream of instruction words over a valid/ready handshake and writes them into consecutive instruction-memory word addresses through the memory's write port (`wen`, `addr`, `data_in`), which stays unused during normal fetch. It holds the pipeline core in reset while loading and releases it once the last word is committed. It sits beside the PC/fetch path at the top level, owns the instruction-memory write side, and is the writer counterpart of the fetch reader.

## Interface
Parameters:
- `ISIZE` — default `` `ISIZE `` from the shared define file; instruction word width.
- `DEPTH` — default 256; instruction memory depth in words.
- `AW` — default 8; write-address width, must equal clog2(`DEPTH`).

Ports:
- `clk`  in  1  single clock; all state on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `in_valid`  in  1  an instruction word is offered.
- `in_data`  in  `ISIZE`  instruction word.
- `in_last`  in  1  marks the final word of the program; qualified by `in_valid`.
- `in_ready`  out  1  the loader accepts a word this cycle.
- `mem_wen`  out  1  instruction-memory write enable.
- `mem_addr`  out  `ISIZE`  write word address, zero-extended from `AW`.
- `mem_data`  out  `ISIZE`  write data.
- `cpu_rst`  out  1  hold-reset to PC, IF/ID register and datapath.
- `done`  out  1  load completed successfully.
- `error`  out  1  load overflowed `DEPTH`.
- `word_count`  out  `AW`+1  number of words written in the current or last load.
- `checksum`  out  `ISIZE`  modulo-2^`ISIZE` sum of the words written.

## Operation
- States: IDLE, LOAD, DONE, ERR. Encoding is a shared localparam.
- IDLE → LOAD on `load_start`. On that edge, clear the address counter, `word_count` and `checksum`.
- In LOAD, `in_ready` = 1. A handshake is `in_valid && in_ready`. On each handshake:
  - register `in_data` into `mem_data` and the counter into `mem_addr`, and set `mem_wen` = 1 for the next cycle;
  - increment the counter and `word_count`;
  - add `in_data` to `checksum`.
- LOAD → DONE on a handshake with `in_last` = 1.
- LOAD → ERR on a handshake with `in_last` = 0 when the counter = `DEPTH`-1. That final word is still written.
- DONE → LOAD on `load_start`. This is a reload; `cpu_rst` reasserts in the same cycle.
- ERR is left only by `rst` or `load_start`; a `load_start` in ERR restarts LOAD.
- `cpu_rst` = 1 in IDLE, LOAD and ERR. It is 0 only in DONE, and only after the final write has been committed.
- `load_start` is ignored while in LOAD.
- `in_valid` outside LOAD is ignored; `in_ready` = 0 there.

## Timing
- Reset values: state IDLE, `in_ready` 0, `mem_wen` 0, `mem_addr` 0, `mem_data` 0, `cpu_rst` 1, `done` 0, `error` 0, `word_count` 0, `checksum` 0.
- Handshake in cycle N → `mem_wen` high in cycle N+1 with the matching `mem_addr`/`mem_data`. Write latency is 1 cycle.
- Back-to-back handshakes give back-to-back writes at one word per cycle with no bubbles.
- `done` rises in the cycle after the `in_last` handshake, coincident with its `mem_wen`.
- `cpu_rst` falls one cycle after that, so the core's first fetch sees the final word committed.
- `error` rises in the cycle after the overflow handshake and holds in ERR.
- A `load_start` in DONE takes effect on the next edge: `done` drops to 0 and `cpu_rst` rises to 1 in the same cycle.
- An `rst` assertion mid-load asynchronously drops `mem_wen` and returns all outputs to their reset values. Partially written memory contents are not cleared.
- `checksum` and `word_count` update on the same edge as the write is registered. They are stable from the `done` or `error` cycle onward.

## Structure
- Shared define file additions: `` `IMEM_DEPTH ``, `` `IMEM_AW ``, and the state localparams.
- Reuse the existing `` `ISIZE ``.
- Single flat module, no sub-modules.
- At the top level, the memory write port is muxed: loader drives it when `cpu_rst` = 1, and it is tied off otherwise.
- `cpu_rst` is ORed with `rst` into the core.

## Test plan
- Reset then idle: outputs match reset values; `in_valid`=1 with `in_data`=0x12345678 → no write, `in_ready`=0.
- Load 4 words 0x00000001, 0x00000002, 0x00000003, 0x00000004, back-to-back, last on the 4th → writes to addresses 0..3 on consecutive cycles; `done`=1; `word_count`=4; `checksum`=0x0000000A; `cpu_rst` falls one cycle after `done`.
- Same 4 words with `in_valid` gaps of 2 cycles between words → identical memory contents, `word_count` and `checksum`; no `mem_wen` in gap cycles.
- `DEPTH`=256 with 256 words and no `in_last` → word 255 written to address 255; `error`=1; `cpu_rst` stays 1; `in_ready`=0 afterward.
- `rst` pulsed after the 2nd of 4 words → `mem_wen` 0 immediately, state IDLE; a new `load_start` restarts at address 0.
- Reload from DONE: `load_start` → `cpu_rst`=1 and `done`=0 next cycle; loading 2 words (0xDEADBEEF, 0x00000001) gives `checksum`=0xDEADBEF0 and `word_count`=2.
